// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: standard mode tables, sync polarity constants
// and the axis-total helper used by the timing generator and its axis counters.
package vga_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz nominal pixel clock (25 MHz in practice)
  localparam axis_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam axis_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2, bp: 33};
  localparam bit           VGA_640X480_POL = SYNC_ACTIVE_LOW;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam axis_timing_t VGA_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam axis_timing_t VGA_800X600_V = '{active: 600, fp: 1, sync: 4, bp: 23};
  localparam bit           VGA_800X600_POL = SYNC_ACTIVE_HIGH;

  function automatic int axis_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int timing_total(input axis_timing_t t);
    return axis_total(t.active, t.fp, t.sync, t.bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping position counter with
// sync and blank decoded from the next-state count so they track count exactly.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = SYNC_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             blank,
  output logic             wrap
);

  localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

`ifdef SYNTHESIS
  localparam bit PORCH_ZERO = (FP < 1) || (BP < 1);
`else
  localparam bit PORCH_ZERO = 1'b0;
`endif

  if (ACTIVE < 1 || SYNC < 1 || PORCH_ZERO) begin : g_zero_segment
    $error("vga_axis_counter: timing segment of zero width");
  end
  if (TOTAL > (1 << CNT_W)) begin : g_total_too_wide
    $error("vga_axis_counter: axis total does not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] count_next;
  logic             at_last;

  assign at_last = (count == LAST);
  assign wrap    = advance & at_last;

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    count_next = count + CNT_W'(1);
    if (at_last) count_next = '0;
  end

  function automatic logic in_sync_window(input logic [CNT_W-1:0] c);
    return (int'(c) >= SYNC_START) && (int'(c) < SYNC_END);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sync  <= ~POL;
      blank <= 1'b0;
    end else if (advance) begin
      count <= count_next;
      sync  <= in_sync_window(count_next) ? POL : ~POL;
      blank <= (int'(count_next) >= ACTIVE);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel-clock divider and run/freeze.
// Define VGA_TIMING_SYNC_DELAY_EN to delay hsync/vsync/blank by SYNC_DELAY pixels.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA_640X480_H.active,
  parameter int H_FP     = VGA_640X480_H.fp,
  parameter int H_SYNC   = VGA_640X480_H.sync,
  parameter int H_BP     = VGA_640X480_H.bp,
  parameter int V_ACTIVE = VGA_640X480_V.active,
  parameter int V_FP     = VGA_640X480_V.fp,
  parameter int V_SYNC   = VGA_640X480_V.sync,
  parameter int V_BP     = VGA_640X480_V.bp,
  parameter bit H_POL    = VGA_640X480_POL,
  parameter bit V_POL    = VGA_640X480_POL
`ifdef VGA_TIMING_SYNC_DELAY_EN
  ,
  parameter int SYNC_DELAY = 2
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             line_start,
  output logic             frame_start
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 1 : 0);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic             rst_done;

  assign div_last = (div_cnt == DIV_LAST);
  // rst_done keeps pix_en low through reset even when CLK_DIV=1
  assign pix_en   = run & div_last & rst_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (run) div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
    end
  end

  logic h_sync, h_blank, h_wrap;
  logic v_sync, v_blank, v_wrap;

  vga_axis_counter #(
    .CNT_W (CNT_W),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .POL   (H_POL)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(pix_en),
    .count  (hcount),
    .sync   (h_sync),
    .blank  (h_blank),
    .wrap   (h_wrap)
  );

  // Vertical axis steps once per line, on the pixel that wraps hcount
  vga_axis_counter #(
    .CNT_W (CNT_W),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .POL   (V_POL)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(h_wrap & pix_en),
    .count  (vcount),
    .sync   (v_sync),
    .blank  (v_blank),
    .wrap   (v_wrap)
  );

  logic line_q;
  logic frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      line_q  <= h_wrap;
      frame_q <= h_wrap & v_wrap;
    end
  end

  assign line_start  = line_q & run;
  assign frame_start = frame_q & run;

`ifdef VGA_TIMING_SYNC_DELAY_EN
  if (SYNC_DELAY < 1) begin : g_bad_sync_delay
    $error("vga_timing_gen: SYNC_DELAY must be at least 1");
  end

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_bus_t;

  localparam sync_bus_t IDLE_BUS = '{hsync: ~H_POL, vsync: ~V_POL, blank: 1'b1};

  sync_bus_t pipe [SYNC_DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this small register array is reset stage by stage so the display
      // sees inactive sync and blanking until real timing has propagated.
      for (int i = 0; i < SYNC_DELAY; i++) pipe[i] <= IDLE_BUS;
    end else if (pix_en) begin
      pipe[0] <= '{hsync: h_sync, vsync: v_sync, blank: h_blank | v_blank};
      for (int i = 1; i < SYNC_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign hsync = pipe[SYNC_DELAY-1].hsync;
  assign vsync = pipe[SYNC_DELAY-1].vsync;
  assign blank = pipe[SYNC_DELAY-1].blank;
`else
  assign hsync = h_sync;
  assign vsync = v_sync;
  assign blank = h_blank | v_blank;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance (CLK_DIV=2) for line timing, freeze
// and reset, plus a tiny custom-timing instance (CLK_DIV=1) for frame-level behaviour.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_SYNC_DELAY_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, run_a, rst_b, run_b;
  logic       pix_en_a, hsync_a, vsync_a, blank_a, line_start_a, frame_start_a;
  logic [9:0] hcount_a, vcount_a;
  logic       pix_en_b, hsync_b, vsync_b, blank_b, line_start_b, frame_start_b;
  logic [3:0] hcount_b, vcount_b;

  int checks   = 0;
  int failures = 0;

  vga_timing_gen #(
    .CNT_W  (10),
    .CLK_DIV(2)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_a),
    .run        (run_a),
    .pix_en     (pix_en_a),
    .hcount     (hcount_a),
    .vcount     (vcount_a),
    .hsync      (hsync_a),
    .vsync      (vsync_a),
    .blank      (blank_a),
    .line_start (line_start_a),
    .frame_start(frame_start_a)
  );

  vga_timing_gen #(
    .CNT_W   (4),
    .CLK_DIV (1),
    .H_ACTIVE(4),
    .H_FP    (1),
    .H_SYNC  (2),
    .H_BP    (1),
    .V_ACTIVE(3),
    .V_FP    (1),
    .V_SYNC  (1),
    .V_BP    (1),
    .H_POL   (1'b1),
    .V_POL   (1'b0)
`ifdef VGA_TIMING_SYNC_DELAY_EN
    ,
    .SYNC_DELAY(2)
`endif
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_b),
    .run        (run_b),
    .pix_en     (pix_en_b),
    .hcount     (hcount_b),
    .vcount     (vcount_b),
    .hsync      (hsync_b),
    .vsync      (vsync_b),
    .blank      (blank_b),
    .line_start (line_start_b),
    .frame_start(frame_start_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input int h, input int v, input int budget, input string tag);
    int n = 0;
    while (!(hcount_a == 10'(h) && vcount_a == 10'(v)) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(hcount_a == 10'(h) && vcount_a == 10'(v)), 1);
  endtask

  task automatic wait_b(input int h, input int v, input int budget, input string tag);
    int n = 0;
    while (!(hcount_b == 4'(h) && vcount_b == 4'(v)) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(hcount_b == 4'(h) && vcount_b == 4'(v)), 1);
  endtask

  // Custom instance: 8 pixels/line, 6 lines/frame; sync/blank lag by DLY pixels
  function automatic logic exp_hs_b(input int h);
    int p = (h - DLY + 16) % 8;
    return (p >= 5) && (p <= 6);
  endfunction

  function automatic logic exp_vs_b(input int k);
    int p = (k - DLY + 48) % 48;
    return (p / 8 == 4) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_blank_b(input int k);
    int p = (k - DLY + 48) % 48;
    return ((p % 8) >= 4) || ((p / 8) >= 3);
  endfunction

  initial begin
    int n, pe, hs, ls, frz_bad;

    rst_a = 1'b0;
    rst_b = 1'b0;
    run_a = 1'b1;
    run_b = 1'b1;
    repeat (3) tick();

    check("a_rst_hcount", 32'(hcount_a), 0);
    check("a_rst_vcount", 32'(vcount_a), 0);
    check("a_rst_pix_en", 32'(pix_en_a), 0);
    check("a_rst_hsync", 32'(hsync_a), 1);
    check("a_rst_vsync", 32'(vsync_a), 1);
    check("a_rst_blank", 32'(blank_a), 0);
    check("a_rst_line_start", 32'(line_start_a), 0);
    check("a_rst_frame_start", 32'(frame_start_a), 0);
    check("b_rst_pix_en", 32'(pix_en_b), 0);
    check("b_rst_hsync", 32'(hsync_b), 0);
    check("b_rst_vsync", 32'(vsync_b), 1);

    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    check("a_rel_pix_en0", 32'(pix_en_a), 0);
    tick();
    check("a_rel_pix_en1", 32'(pix_en_a), 1);
    check("a_rel_hcount0", 32'(hcount_a), 0);
    tick();
    check("a_rel_pix_en2", 32'(pix_en_a), 0);
    check("a_rel_hcount1", 32'(hcount_a), 1);
    check("b_pix_en_run", 32'(pix_en_b), 1);
    check("b_hcount_first", 32'(hcount_b), 1);

    // Custom instance: hsync window (5..6 undelayed) and undelayed counters
    wait_b(4, 1, 100, "b_reach_4_1");
    for (int i = 0; i < 5; i++) begin
      check("b_hcount_walk", 32'(hcount_b), 32'((4 + i) % 8));
      check("b_hsync_walk", 32'(hsync_b), 32'(exp_hs_b(4 + i)));
      tick();
    end

    // Custom instance: vsync on line 4 only, blank for lines 3..5
    wait_b(0, 4, 100, "b_reach_0_4");
    for (int i = 0; i < 14; i++) begin
      check("b_vsync_walk", 32'(vsync_b), 32'(exp_vs_b(32 + i)));
      check("b_blank_walk", 32'(blank_b), 32'(exp_blank_b(32 + i)));
      tick();
    end

    wait_b(7, 5, 100, "b_reach_7_5");
    check("b_fs_before_wrap", 32'(frame_start_b), 0);
    tick();
    check("b_wrap_hcount", 32'(hcount_b), 0);
    check("b_wrap_vcount", 32'(vcount_b), 0);
    check("b_wrap_frame_start", 32'(frame_start_b), 1);
    check("b_wrap_line_start", 32'(line_start_b), 1);

    n  = 0;
    ls = 0;
    do begin
      tick();
      n++;
      if (line_start_b) ls++;
    end while (!frame_start_b && n < 200);
    check("b_frame_period_clks", 32'(n), 48);
    check("b_line_starts_per_frame", 32'(ls), 6);

    // Default instance: horizontal blank and sync window on line 0
    wait_a(639, 0, 3000, "a_reach_639");
    check("a_blank_639", 32'(blank_a), 0);
    wait_a(640, 0, 10, "a_reach_640");
    check("a_blank_640", 32'(blank_a), 1);
    wait_a(655, 0, 100, "a_reach_655");
    check("a_hsync_655", 32'(hsync_a), 1);
    wait_a(656, 0, 10, "a_reach_656");
    check("a_hsync_656", 32'(hsync_a), 0);
    wait_a(751, 0, 300, "a_reach_751");
    check("a_hsync_751", 32'(hsync_a), 0);
    wait_a(752, 0, 10, "a_reach_752");
    check("a_hsync_752", 32'(hsync_a), 1);
    wait_a(799, 0, 200, "a_reach_799");
    check("a_blank_799", 32'(blank_a), 1);
    check("a_line_start_799", 32'(line_start_a), 0);

    wait_a(0, 1, 10, "a_reach_0_1");
    check("a_line_start_wrap", 32'(line_start_a), 1);
    check("a_frame_start_wrap", 32'(frame_start_a), 0);
    check("a_blank_0_1", 32'(blank_a), 0);
    check("a_vsync_line1", 32'(vsync_a), 1);
    tick();
    check("a_line_start_one_clk", 32'(line_start_a), 0);
    check("a_hcount_held", 32'(hcount_a), 0);

    // Full line 1: clocks, pixel strobes and hsync-low pixels
    n  = 1;
    pe = 0;
    hs = 0;
    do begin
      if (pix_en_a) pe++;
      if (pix_en_a && !hsync_a) hs++;
      tick();
      n++;
    end while (!(hcount_a == 10'd0 && vcount_a == 10'd2) && n < 4000);
    check("a_line_clks", 32'(n), 1600);
    check("a_line_pix_en", 32'(pe), 800);
    check("a_line_hsync_pixels", 32'(hs), 96);

    // Freeze at hcount=700 for 50 clocks
    wait_a(700, 2, 2000, "a_reach_700");
    run_a = 1'b0;
    #1;
    frz_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (hcount_a !== 10'd700 || vcount_a !== 10'd2 || pix_en_a !== 1'b0 ||
          hsync_a !== 1'b0 || blank_a !== 1'b1)
        frz_bad++;
      tick();
    end
    check("a_freeze_violations", 32'(frz_bad), 0);
    run_a = 1'b1;
    #1;
    check("a_resume_pix_en0", 32'(pix_en_a), 0);
    tick();
    check("a_resume_pix_en1", 32'(pix_en_a), 1);
    check("a_resume_hcount700", 32'(hcount_a), 700);
    tick();
    check("a_resume_hcount701", 32'(hcount_a), 701);

    // run dropped on the wrapping pixel: wrap must not happen
    wait_a(799, 2, 400, "a_reach_799_2");
    tick();
    check("a_wrap_pix_en", 32'(pix_en_a), 1);
    run_a = 1'b0;
    #1;
    check("a_wrap_frozen_pix_en", 32'(pix_en_a), 0);
    repeat (3) tick();
    check("a_wrap_frozen_hcount", 32'(hcount_a), 799);
    check("a_wrap_frozen_line_start", 32'(line_start_a), 0);
    run_a = 1'b1;
    #1;
    check("a_wrap_resume_pix_en", 32'(pix_en_a), 1);
    tick();
    check("a_wrap_resume_hcount", 32'(hcount_a), 0);
    check("a_wrap_resume_vcount", 32'(vcount_a), 3);
    check("a_wrap_resume_line_start", 32'(line_start_a), 1);

    // Asynchronous reset mid-line
    wait_a(300, 3, 1000, "a_reach_300_3");
    rst_a = 1'b0;
    #1;
    check("a_midrst_hcount", 32'(hcount_a), 0);
    check("a_midrst_vcount", 32'(vcount_a), 0);
    check("a_midrst_pix_en", 32'(pix_en_a), 0);
    check("a_midrst_hsync", 32'(hsync_a), 1);
    check("a_midrst_vsync", 32'(vsync_a), 1);
    check("a_midrst_blank", 32'(blank_a), 0);
    check("a_midrst_line_start", 32'(line_start_a), 0);
    repeat (2) tick();
    rst_a = 1'b1;
    tick();
    check("a_postrst_pix_en", 32'(pix_en_a), 1);
    check("a_postrst_hcount0", 32'(hcount_a), 0);
    tick();
    check("a_postrst_hcount1", 32'(hcount_a), 1);
    check("a_postrst_vcount", 32'(vcount_a), 0);
    check("a_postrst_line_start", 32'(line_start_a), 0);
    check("a_postrst_frame_start", 32'(frame_start_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator that supersedes the fixed 640x480 sync block. Porch, sync and active widths, sync polarity, pixel-clock divide and counter width are set per axis by parameters. Adds a run/freeze control, line/frame strobes and a clean asynchronous reset. Sits between the system clock and the pixel pipeline / frame-buffer reader.

Parameters:
CNT_W, 10, width of hcount/vcount; H_TOTAL and V_TOTAL must each be <= 2**CNT_W
CLK_DIV, 2, system clocks per pixel (>=1); 2 gives 25 MHz pixel rate from 50 MHz
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, hsync pulse width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vsync width, in lines
V_BP, 33, vertical back porch, in lines
H_POL, 0, hsync active level (0 = active low)
V_POL, 0, vsync active level (0 = active low)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
run  in  1  1 = timing advances; 0 = freeze at current position
pix_en  out  1  one-clk pixel strobe
hcount  out  CNT_W  pixel index on the current line
vcount  out  CNT_W  line index
hsync  out  1  horizontal sync, polarity H_POL
vsync  out  1  vertical sync, polarity V_POL
blank  out  1  1 outside the active area
line_start  out  1  one-clk pulse on entry to hcount=0
frame_start  out  1  one-clk pulse on entry to (0,0)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values: div counter 0; hcount=0; vcount=0; pix_en=0; hsync=~H_POL; vsync=~V_POL; blank=0; line_start=0; frame_start=0.
- Divider: div_cnt counts 0..CLK_DIV-1 while run=1. pix_en is asserted in the clk cycle where div_cnt==CLK_DIV-1 and run=1. With CLK_DIV=1, pix_en=run.
- run=0: div_cnt, counters and all decoded outputs hold their values. pix_en, line_start and frame_start are 0.
- Horizontal counter, on each pix_en: hcount = (hcount==H_TOTAL-1) ? 0 : hcount+1.
- Vertical counter: advances only on a pix_en where hcount==H_TOTAL-1. It wraps from V_TOTAL-1 to 0.
- Decoded outputs are registered from the next-state counter values, so on any cycle they describe the hcount/vcount visible on that same cycle (zero relative latency).
  - hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
  - vsync edges coincide with the hcount wrap.
  - blank = (hcount >= H_ACTIVE) | (vcount >= V_ACTIVE).
- line_start is high for the single clk in which hcount becomes 0 by wrap. frame_start is high when both counters wrap together. Neither pulses after reset release.
- Reset mid-frame: every register returns to its reset value immediately (asynchronous). Counting resumes at (0,0) on the first pix_en after deassertion.
- run deasserted on the same cycle as a wrap: the wrap does not occur (pix_en=0).
- Elaboration-time errors:
  - any timing parameter is 0 (porches may be 0 only in simulation builds);
  - CLK_DIV < 1;
  - a total exceeds 2**CNT_W.

Optional Feature:
Macro VGA_TIMING_SYNC_DELAY_EN adds parameter SYNC_DELAY (default 2, >=1).
- Defined: hsync, vsync and blank pass through a SYNC_DELAY-deep shift register advanced only on pix_en. This aligns them with a pixel pipeline of that latency. hcount, vcount, line_start and frame_start are not delayed. Shift stages reset to inactive sync levels and blank=1.
- Undefined: outputs are exactly as described above, with zero delay.

Decomposition:
- Package vga_timing_pkg holds:
  - localparams for standard 640x480@60 and 800x600@60 timing;
  - a function computing totals;
  - the sync polarity constants.
- One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical).
  - Inputs: advance strobe, ACTIVE/FP/SYNC/BP/POL parameters.
  - Outputs: count, sync, blank, wrap.
  - The vertical instance uses horizontal wrap & pix_en as its advance strobe.

Test Plan:
- Defaults, CLK_DIV=2, run=1 for 2 frames -> pix_en every 2nd clk; hcount wraps 799->0; vcount wraps 524->0; frame period 840000 clks.
- Horizontal sync/blank window -> hsync low exactly for hcount 656..751 (96 pixels); blank rises at hcount=640 and falls at hcount=0 on visible lines.
- Vertical sync/blank window -> vsync low for vcount 490..491; blank held 1 for all of vcount 480..524; frame_start pulses once per frame at (0,0).
- run dropped at hcount=700 for 50 clks -> counters, hsync and blank frozen; no pix_en; resumes at 701.
- rst_n asserted mid-line at (300,200) -> all outputs take reset values the same cycle; first strobe after release gives hcount=1.
- Custom params (H 4/1/2/1, V 3/1/1/1, H_POL=1, CLK_DIV=1) with VGA_TIMING_SYNC_DELAY_EN and SYNC_DELAY=2 -> hsync high for hcount 5..6, observed 2 pix_en later; counters undelayed.
